// File: rtl/multisim_apb_pkg.sv
// Shared APB types for the multisim APB blocks: request/response structs and the
// manager-side transfer state.
package multisim_apb_pkg;

   typedef struct packed {
      logic [31:0] paddr;
      logic        pwrite;
      logic [31:0] pwdata;
      logic [3:0]  pstrb;
      logic [2:0]  pprot;
   } apb_req_t;

   typedef struct packed {
      logic [31:0] prdata;
      logic        pslverr;
   } apb_resp_t;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } multisim_apb_state_t;

endpackage

// File: rtl/multisim_rr_picker.sv
// Combinational round-robin picker: first asserted request after last_grant,
// wrapping modulo N.
module multisim_rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_grant,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] cand;

   // Scan from the farthest offset down so the nearest requester is written last.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int off = N; off >= 1; off--) begin
         cand = IDX_W'((int'(last_grant) + off) % N);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/multisim_apb_arbiter.sv
// Round-robin arbiter sharing one APB manager port among NUM_REQ requesters; it
// drives the manager SETUP/ACCESS phases and stalls requesters until completion.
//
// state  | meaning
// IDLE   | no transfer; arbitrate among requesters with psel high
// SETUP  | manager psel=1, penable=0 for the granted requester
// ACCESS | manager psel=1, penable=1; wait for manager pready
module multisim_apb_arbiter
   import multisim_apb_pkg::*;
#(
   parameter type apb_req_t  = multisim_apb_pkg::apb_req_t,
   parameter type apb_resp_t = multisim_apb_pkg::apb_resp_t,
   parameter int  NUM_REQ    = 4,
   localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  apb_req_t  [NUM_REQ-1:0]       i_apb_s_req,
   input  logic      [NUM_REQ-1:0]       i_apb_s_psel,
   input  logic      [NUM_REQ-1:0]       i_apb_s_penable,
   output apb_resp_t [NUM_REQ-1:0]       o_apb_s_resp,
   output logic      [NUM_REQ-1:0]       o_apb_s_pready,
   output apb_req_t                      o_apb_m_req,
   output logic                          o_apb_m_psel,
   output logic                          o_apb_m_penable,
   input  apb_resp_t                     i_apb_m_resp,
   input  logic                          i_apb_m_pready,
   output logic      [IDX_W-1:0]         o_grant_idx,
   output logic                          o_busy
);

   multisim_apb_state_t state;
   logic [IDX_W-1:0]    grant;
   logic [IDX_W-1:0]    last_grant;
   logic                pick_valid;
   logic [IDX_W-1:0]    pick_idx;

   // Requester penable carries no arbitration meaning; psel alone is the request.
   logic unused_penable;
   assign unused_penable = ^i_apb_s_penable;

   multisim_rr_picker #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req        (i_apb_s_psel),
      .last_grant (last_grant),
      .valid      (pick_valid),
      .idx        (pick_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         grant           <= '0;
         last_grant      <= IDX_W'(NUM_REQ - 1);
         o_apb_m_psel    <= 1'b0;
         o_apb_m_penable <= 1'b0;
         o_busy          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant        <= pick_idx;
                  state        <= SETUP;
                  o_apb_m_psel <= 1'b1;
                  o_busy       <= 1'b1;
               end
            end
            SETUP: begin
               state           <= ACCESS;
               o_apb_m_penable <= 1'b1;
            end
            ACCESS: begin
               if (i_apb_m_pready) begin
                  last_grant      <= grant;
                  state           <= IDLE;
                  o_apb_m_psel    <= 1'b0;
                  o_apb_m_penable <= 1'b0;
                  o_busy          <= 1'b0;
               end
            end
            default: begin
               state           <= IDLE;
               o_apb_m_psel    <= 1'b0;
               o_apb_m_penable <= 1'b0;
               o_busy          <= 1'b0;
            end
         endcase
      end
   end

   assign o_grant_idx = grant;
   assign o_apb_m_req = (state != IDLE) ? i_apb_s_req[grant] : '0;

   // A requester that dropped psel mid-transfer never sees the completion.
   always_comb begin
      o_apb_s_pready = '0;
      if (state == ACCESS && i_apb_m_pready && i_apb_s_psel[grant])
         o_apb_s_pready[grant] = 1'b1;
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++)
         o_apb_s_resp[i] = i_apb_m_resp;
   end

endmodule

// File: tb/tb_multisim_apb_arbiter.sv
// Directed bench for multisim_apb_arbiter: stimulus queues expected completions,
// a negedge monitor pops and checks them as requester pready appears.
module tb_multisim_apb_arbiter;
   import multisim_apb_pkg::*;

   localparam int NR = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   apb_req_t  [NR-1:0]  s_req;
   logic      [NR-1:0]  s_psel = '0;
   logic      [NR-1:0]  s_penable = '0;
   apb_resp_t [NR-1:0]  s_resp;
   logic      [NR-1:0]  s_pready;
   apb_req_t            m_req;
   logic                m_psel;
   logic                m_penable;
   apb_resp_t           m_resp;
   logic                m_pready;
   logic      [1:0]     grant_idx;
   logic                busy;

   multisim_apb_arbiter #(.NUM_REQ(NR)) dut (
      .clk             (clk),
      .rst             (rst),
      .i_apb_s_req     (s_req),
      .i_apb_s_psel    (s_psel),
      .i_apb_s_penable (s_penable),
      .o_apb_s_resp    (s_resp),
      .o_apb_s_pready  (s_pready),
      .o_apb_m_req     (m_req),
      .o_apb_m_psel    (m_psel),
      .o_apb_m_penable (m_penable),
      .i_apb_m_resp    (m_resp),
      .i_apb_m_pready  (m_pready),
      .o_grant_idx     (grant_idx),
      .o_busy          (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  idx;
      int          cycle;
      logic [31:0] prdata;
      logic        slverr;
   } exp_t;

   exp_t      sb[$];
   int        checks = 0;
   int        failures = 0;
   int        cyc = 0;
   int        pend[NR];
   int        wait_states = 0;
   logic [NR-1:0] slverr_mask = '0;
   logic [NR-1:0] rdy_s;
   logic [7:0]    acc_cnt;

   function automatic apb_req_t req_of(input int i);
      apb_req_t r;
      r.paddr  = 32'(i);
      r.pwrite = i[0];
      r.pwdata = 32'h5A5A_0000 | 32'(i);
      r.pstrb  = 4'hF;
      r.pprot  = 3'(i);
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Subordinate model: inserts wait_states ACCESS wait cycles, data derived from paddr.
   always @(posedge clk or posedge rst) begin
      if (rst) acc_cnt <= '0;
      else if (m_psel && m_penable && !m_pready) acc_cnt <= acc_cnt + 8'd1;
      else acc_cnt <= '0;
   end
   assign m_pready = m_psel && m_penable && (int'(acc_cnt) >= wait_states);
   always_comb begin
      m_resp.prdata  = {16'hCAFE, 12'h000, m_req.paddr[3:0]};
      m_resp.pslverr = slverr_mask[m_req.paddr[1:0]];
   end

   // Monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (m_psel && sb.size() > 0) begin
            checks++;
            if (m_req !== req_of(int'(sb[0].idx))) begin
               failures++;
               $display("FAIL m_req cyc=%0d got=%h want=%h", cyc, m_req, req_of(int'(sb[0].idx)));
            end
         end
         if (s_pready != '0) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_pready cyc=%0d got=%b want=0000", cyc, s_pready);
            end else begin
               exp_t e;
               apb_resp_t er;
               e = sb.pop_front();
               er.prdata  = e.prdata;
               er.pslverr = e.slverr;
               if (s_pready !== (NR'(1) << e.idx) || grant_idx !== e.idx || cyc != e.cycle ||
                   s_resp[e.idx] !== er) begin
                  failures++;
                  $display("FAIL completion got pready=%b grant=%0d cyc=%0d resp=%h want pready=%b grant=%0d cyc=%0d resp=%h",
                           s_pready, grant_idx, cyc, s_resp[e.idx], NR'(1) << e.idx, e.idx, e.cycle, er);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      rdy_s = s_pready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (rdy_s[i] && pend[i] > 0) pend[i]--;
         s_penable[i] = s_psel[i] && (pend[i] > 0);
         s_psel[i]    = pend[i] > 0;
      end
   endtask

   task automatic issue(input int i, input int n);
      pend[i] += n;
      s_psel[i] = 1'b1;
   endtask

   task automatic expect_done(input int i, input int at, input logic err);
      exp_t e;
      e.idx    = 2'(i);
      e.cycle  = at;
      e.prdata = 32'hCAFE_0000 | 32'(i);
      e.slverr = err;
      sb.push_back(e);
   endtask

   function automatic bit any_pend();
      for (int i = 0; i < NR; i++) if (pend[i] > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((any_pend() || sb.size() != 0 || m_psel) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL %s_timeout got=%0d_cycles want<%0d pending_exp=%0d", name, n, budget, sb.size());
         sb.delete();
         for (int i = 0; i < NR; i++) pend[i] = 0;
         s_psel = '0;
      end
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < NR; i++) pend[i] = 0;
      s_psel = '0;
      s_penable = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int c0;
      for (int i = 0; i < NR; i++) begin
         s_req[i] = req_of(i);
         pend[i]  = 0;
      end
      #1;
      check("rst_m_psel", 64'(m_psel), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_m_req", 64'(m_req), 64'd0);
      do_reset();

      // Single request from requester 2
      c0 = cyc;
      issue(2, 1);
      expect_done(2, c0 + 2, 1'b0);
      tick();
      check("s1_setup", {62'd0, m_psel, m_penable}, 64'b10);
      tick();
      check("s1_access", {62'd0, m_psel, m_penable}, 64'b11);
      wait_idle("s1", 20);

      // All requesters after reset: 0,1,2,3,0
      do_reset();
      c0 = cyc;
      issue(0, 2); issue(1, 1); issue(2, 1); issue(3, 1);
      expect_done(0, c0 + 2, 1'b0);
      expect_done(1, c0 + 5, 1'b0);
      expect_done(2, c0 + 8, 1'b0);
      expect_done(3, c0 + 11, 1'b0);
      expect_done(0, c0 + 14, 1'b0);
      wait_idle("s2", 40);

      // Five wait states on requester 1
      wait_states = 5;
      c0 = cyc;
      issue(1, 1);
      expect_done(1, c0 + 7, 1'b0);
      wait_idle("s3", 30);
      wait_states = 0;

      // 1 just completed: 3 beats 1
      c0 = cyc;
      issue(1, 1); issue(3, 1);
      expect_done(3, c0 + 2, 1'b0);
      expect_done(1, c0 + 5, 1'b0);
      wait_idle("s4", 30);

      // Error response forwarded, then normal continuation
      slverr_mask = 4'b0100;
      c0 = cyc;
      issue(0, 1); issue(2, 1);
      expect_done(2, c0 + 2, 1'b1);
      expect_done(0, c0 + 5, 1'b0);
      wait_idle("s5", 30);
      slverr_mask = '0;

      // Reset in the middle of requester 0's ACCESS
      wait_states = 20;
      issue(0, 1);
      repeat (3) tick();
      check("s6_pre_penable", 64'(m_penable), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("s6_async_outs", {60'd0, m_psel, m_penable, busy, |s_pready}, 64'd0);
      check("s6_async_grant", 64'(grant_idx), 64'd0);
      check("s6_async_mreq", 64'(m_req), 64'd0);
      wait_states = 0;
      do_reset();
      c0 = cyc;
      issue(0, 1); issue(1, 1);
      expect_done(0, c0 + 2, 1'b0);
      expect_done(1, c0 + 5, 1'b0);
      wait_idle("s6", 30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
